store_request_sequencer: RTL and testbench



---
 rtl/store_request_sequencer_pkg.sv | 21 ++
 rtl/store_request_sequencer_if.sv | 27 ++
 rtl/store_request_sequencer_sync_2ff.sv | 26 ++
 rtl/store_request_sequencer.sv | 123 ++++++++++++
 tb/tb_store_request_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/store_request_sequencer_pkg.sv
// Shared types and constants for the store request front end of the 4-byte memory system.
package store_request_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STORE    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_REL_DB   = 3'd5
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 2;
  localparam int BOARD_CLK_HZ = 100_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/store_request_sequencer_if.sv
// Board-side inputs and memory-side outputs of the store request sequencer.
interface store_request_sequencer_if
  import store_request_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              btn_store;
  logic [DATA_W-1:0] sw_data;
  logic [ADDR_W-1:0] sw_addr;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic              store_out;
  logic              busy;

  modport master (
    output btn_store, sw_data, sw_addr,
    input  data_out, addr_out, store_out, busy
  );

  modport slave (
    input  btn_store, sw_data, sw_addr,
    output data_out, addr_out, store_out, busy
  );

endinterface

// File: rtl/store_request_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/store_request_sequencer.sv
// Debounces the store button and turns each accepted press into one fixed-length store
// strobe, with data/address snapshotted from the switches and held stable around it.
module store_request_sequencer
  import store_request_sequencer_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int STORE_CYC    = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  store_request_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYC, STORE_CYC)) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STORE_CYC - 1);

  logic              w_btn_s;
  logic [DATA_W-1:0] w_sw_data_s;
  logic [ADDR_W-1:0] w_sw_addr_s;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_store;
  logic              r_busy;

  sync_2ff #(.W(1)) u_sync_btn (
    .clk(clk), .rst_n(rst_n), .i_d(bus.btn_store), .o_q(w_btn_s)
  );

  sync_2ff #(.W(DATA_W)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sw_data), .o_q(w_sw_data_s)
  );

  sync_2ff #(.W(ADDR_W)) u_sync_addr (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sw_addr), .o_q(w_sw_addr_s)
  );

  // busy is set/cleared alongside every transition into/out of IDLE so it stays registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state <= ST_PRESS_DB;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_SETUP;
            r_cnt   <= '0;
            r_data  <= w_sw_data_s;
            r_addr  <= w_sw_addr_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STORE;
          r_cnt   <= '0;
          r_store <= 1'b1;
        end
        ST_STORE: begin
          if (r_cnt == ST_LAST) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_store <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_btn_s) begin
            r_state <= ST_REL_DB;
            r_cnt   <= '0;
          end
        end
        ST_REL_DB: begin
          // A re-press before the release is debounced falls back to HOLD, so no new store
          if (w_btn_s) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_store <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = r_data;
  assign bus.addr_out  = r_addr;
  assign bus.store_out = r_store;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_store_request_sequencer.sv
// Scoreboard bench: each expected store is queued by the stimulus; a monitor matches store pulses.
module tb_store_request_sequencer;

  logic clk;
  logic rst_n;

  store_request_sequencer_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  store_request_sequencer #(
    .DATA_W(8), .ADDR_W(2), .DEBOUNCE_CYC(4), .STORE_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_store = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected entry per store pulse and checks its length
  logic       in_pulse = 1'b0;
  int         plen = 0;
  logic [7:0] prev_data = '0;
  logic [1:0] prev_addr = '0;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 1'b0;
      plen     = 0;
    end else if (bus.store_out) begin
      if (!in_pulse) begin
        n_store++;
        if (exp_q.size() == 0) begin
          check("unexpected_store", 32'(n_store), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("store_data", 32'(bus.data_out), 32'(e.d));
          check("store_addr", 32'(bus.addr_out), 32'(e.a));
          check("data_pre_stable", 32'(prev_data), 32'(e.d));
          check("addr_pre_stable", 32'(prev_addr), 32'(e.a));
        end
        in_pulse = 1'b1;
        plen     = 1;
      end else begin
        plen++;
      end
    end else if (in_pulse) begin
      check("store_len", 32'(plen), 32'(2));
      in_pulse = 1'b0;
      plen     = 0;
    end
    prev_data = bus.data_out;
    prev_addr = bus.addr_out;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] d, input logic [1:0] a, input int hold);
    bus.sw_data = d;
    bus.sw_addr = a;
    exp_q.push_back('{d: d, a: a});
    bus.btn_store = 1'b1;
    cyc(hold);
    bus.btn_store = 1'b0;
  endtask

  initial begin
    bit seen;

    // 1: reset with button and switches active
    rst_n         = 1'b0;
    bus.btn_store = 1'b1;
    bus.sw_data   = 8'hFF;
    bus.sw_addr   = 2'b11;
    cyc(3);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_addr", 32'(bus.addr_out), 32'h0);
    check("rst_store", 32'(bus.store_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    bus.btn_store = 1'b0;
    rst_n = 1'b1;
    cyc(50);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // 2: clean press
    bus.sw_data = 8'hA5;
    bus.sw_addr = 2'b10;
    exp_q.push_back('{d: 8'hA5, a: 2'b10});
    bus.btn_store = 1'b1;
    cyc(15);
    check("held_busy", 32'(bus.busy), 32'h1);
    cyc(5);
    bus.btn_store = 1'b0;
    cyc(20);
    check("released_busy", 32'(bus.busy), 32'h0);
    check("t2_data", 32'(bus.data_out), 32'hA5);
    check("t2_addr", 32'(bus.addr_out), 32'h2);

    // 3: bounce never reaches the debounce count
    for (int i = 0; i < 2; i++) begin
      bus.btn_store = 1'b1;
      cyc(2);
      bus.btn_store = 1'b0;
      cyc(2);
    end
    cyc(20);
    check("bounce_data", 32'(bus.data_out), 32'hA5);
    check("bounce_busy", 32'(bus.busy), 32'h0);

    // 4: switch change after capture is ignored
    bus.sw_data = 8'h3C;
    bus.sw_addr = 2'b01;
    exp_q.push_back('{d: 8'h3C, a: 2'b01});
    bus.btn_store = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.store_out) seen = 1'b1;
    end
    check("t4_store_seen", 32'(seen), 32'h1);
    bus.sw_data = 8'hC3;
    cyc(10);
    check("t4_hold_data", 32'(bus.data_out), 32'h3C);
    bus.btn_store = 1'b0;
    cyc(20);
    check("t4_after_data", 32'(bus.data_out), 32'h3C);

    // 5: long hold, release glitch, then a fresh press
    bus.sw_data = 8'h5A;
    bus.sw_addr = 2'b00;
    exp_q.push_back('{d: 8'h5A, a: 2'b00});
    bus.btn_store = 1'b1;
    cyc(100);
    bus.btn_store = 1'b0;
    cyc(2);
    bus.btn_store = 1'b1;
    cyc(20);
    check("glitch_busy", 32'(bus.busy), 32'h1);
    bus.btn_store = 1'b0;
    cyc(20);
    check("t5_rel_busy", 32'(bus.busy), 32'h0);
    press(8'h77, 2'b11, 20);
    cyc(20);
    check("t5_data", 32'(bus.data_out), 32'h77);
    check("t5_addr", 32'(bus.addr_out), 32'h3);

    // 6: reset during the first store cycle
    bus.sw_data = 8'hE1;
    bus.sw_addr = 2'b10;
    exp_q.push_back('{d: 8'hE1, a: 2'b10});
    bus.btn_store = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.store_out) seen = 1'b1;
    end
    check("t6_store_seen", 32'(seen), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_store", 32'(bus.store_out), 32'h0);
    check("async_data", 32'(bus.data_out), 32'h0);
    check("async_addr", 32'(bus.addr_out), 32'h0);
    check("async_busy", 32'(bus.busy), 32'h0);
    bus.btn_store = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    check("post_rst_busy", 32'(bus.busy), 32'h0);
    check("post_rst_store", 32'(bus.store_out), 32'h0);
    check("post_rst_data", 32'(bus.data_out), 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("store_count", 32'(n_store), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
